// File: rtl/ram2_arbiter.sv
// Shares the single RAM2 port between instruction fetch and MEM-stage data
// accesses below 0x8000, stalling the pipeline while a data access owns the port.
module ram2_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        isread_mem_i,
  input  logic        iswrite_mem_i,
  input  logic [15:0] addr_mem_i,
  input  logic [15:0] data_mem_i,
  input  logic [15:0] addr_if_i,
  input  logic [15:0] ram2res_i,
  output logic        is_RAM2_mem_o,
  output logic [17:0] addr_mem_o,
  output logic [15:0] data_mem_o,
  output logic        isread_mem_o,
  output logic        iswrite_mem_o,
  output logic [15:0] addr_if_o,
  output logic [15:0] inst_o,
  output logic        inst_valid_o,
  output logic [15:0] load_data_o,
  output logic        mem_done_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam logic [15:0] NOP_INSN   = 16'h0800;
  localparam logic [15:0] RAM2_LIMIT = 16'h8000;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_isread;
  logic        r_iswrite;
  logic [15:0] r_inst;
  logic        r_instValid;
  logic [15:0] r_loadData;
  logic        r_err;
  logic        w_oneFlag;
  logic        w_hit;
  logic        w_illegal;

  // Gating with rst keeps stall_o low while reset is held.
  assign w_oneFlag = isread_mem_i ^ iswrite_mem_i;
  assign w_hit     = rst & mem_req_i & (addr_mem_i < RAM2_LIMIT) & w_oneFlag;
  assign w_illegal = mem_req_i & ~w_oneFlag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    is_RAM2_mem_o = 1'b0;
    stall_o       = 1'b0;
    mem_done_o    = 1'b0;
    isread_mem_o  = 1'b0;
    iswrite_mem_o = 1'b0;
    case (r_state)
      IDLE: begin
        stall_o = w_hit;
        if (w_hit) w_nextState = MEM;
      end
      MEM: begin
        is_RAM2_mem_o = 1'b1;
        stall_o       = 1'b1;
        isread_mem_o  = r_isread;
        iswrite_mem_o = r_iswrite;
        w_nextState   = DONE;
      end
      DONE: begin
        mem_done_o  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Fetch data is captured every cycle except the one where the data access owns the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_isread    <= 1'b0;
      r_iswrite   <= 1'b0;
      r_inst      <= NOP_INSN;
      r_instValid <= 1'b0;
      r_loadData  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) & w_illegal;
      if (r_state == IDLE && w_hit) begin
        r_addr    <= addr_mem_i;
        r_data    <= data_mem_i;
        r_isread  <= isread_mem_i;
        r_iswrite <= iswrite_mem_i;
      end
      if (r_state == MEM) begin
        r_inst      <= NOP_INSN;
        r_instValid <= 1'b0;
        if (r_isread) r_loadData <= ram2res_i;
      end else begin
        r_inst      <= ram2res_i;
        r_instValid <= 1'b1;
      end
    end
  end

  assign addr_mem_o   = {2'b00, r_addr};
  assign data_mem_o   = r_data;
  assign addr_if_o    = addr_if_i;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_instValid;
  assign load_data_o  = r_loadData;
  assign err_o        = r_err;

endmodule
